// File: rtl/pic_pkg.sv
// Shared PIC_RISC datapath definitions: sequencer states, special file
// addresses and the Data_Memory rd_wr encoding.
package pic_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FADDR_W = 7;
  localparam int unsigned ADDR_W  = 8;

  localparam logic [FADDR_W-1:0] INDF_ADDR = 7'h00;
  localparam logic [FADDR_W-1:0] FSR_ADDR  = 7'h04;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_OP   = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/ea_gen.sv
// Effective-address generator: direct {bank, f} or indirect through FSR.
// An indirect access whose FSR points back at INDF is flagged as a null access.
module ea_gen
  import pic_pkg::*;
(
  input  logic [FADDR_W-1:0] req_faddr,
  input  logic               req_rp,
  input  logic [ADDR_W-1:0]  fsr,
  output logic [ADDR_W-1:0]  ea,
  output logic               null_ref
);

  logic indirect;

  assign indirect = (req_faddr == INDF_ADDR);
  assign ea       = indirect ? fsr : {req_rp, req_faddr};
  assign null_ref = indirect && (fsr[FADDR_W-1:0] == INDF_ADDR);

endmodule

// File: rtl/file_reg_access.sv
// Operand-fetch / write-back sequencer in front of Data_Memory. Resolves the
// effective address, fetches the operand for the ALU and writes the result
// to memory or W, keeping a shadow FSR from its own writes.
module file_reg_access
  import pic_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FADDR_W-1:0] req_faddr,
  input  logic               req_rp,
  input  logic               req_rd,
  input  logic               req_wb,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               op_valid,
  output logic [DATA_W-1:0]  op_data,
  input  logic               res_valid,
  input  logic [DATA_W-1:0]  res_data,
  output logic               w_we,
  output logic [DATA_W-1:0]  w_data,
  output logic               mem_rd_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   fsr, fsr_n;
  logic [ADDR_W-1:0]   ea_c, ea_q, ea_n;
  logic                null_c, null_q, null_n;
  logic                dest_mem_q, dest_mem_n;
  logic [DATA_W-1:0]   result_q, result_n;
  logic                accept;
  logic                mem_write_n;
  logic                req_ready_n, op_valid_n, w_we_n, mem_rd_wr_n;
  logic [DATA_W-1:0]   op_data_n, w_data_n, mem_wdata_n;
  logic [ADDR_W-1:0]   mem_addr_n;

  ea_gen u_ea_gen (
    .req_faddr (req_faddr),
    .req_rp    (req_rp),
    .fsr       (fsr),
    .ea        (ea_c),
    .null_ref  (null_c)
  );

  assign accept = req_valid && req_ready;
  assign busy   = !req_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = req_rd ? ST_RD : ST_WB;
      ST_RD:   next_state = ST_CAP;
      ST_CAP:  next_state = ST_OP;
      ST_OP:   if (res_valid) next_state = ST_WB;
      ST_WB:   next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the operation context
  always_comb begin
    ea_n       = ea_q;
    null_n     = null_q;
    dest_mem_n = dest_mem_q;
    result_n   = result_q;
    if (accept) begin
      ea_n       = ea_c;
      null_n     = null_c;
      dest_mem_n = !req_rd || req_wb;
      if (!req_rd) result_n = req_wdata;
    end else if ((state == ST_OP) && res_valid) begin
      result_n = res_data;
    end

    op_data_n = op_data;
    if (state == ST_CAP) op_data_n = null_q ? DATA_W'(0) : mem_rdata;

    mem_write_n = (next_state == ST_WB) && dest_mem_n && !null_n;
    req_ready_n = (next_state == ST_IDLE);
    op_valid_n  = (next_state == ST_OP);
    w_we_n      = (next_state == ST_WB) && !dest_mem_n;
    w_data_n    = w_we_n ? result_n : w_data;
    mem_rd_wr_n = mem_write_n ? WR : RD;
    mem_addr_n  = ((next_state == ST_RD) || (next_state == ST_WB)) ? ea_n : mem_addr;
    mem_wdata_n = mem_write_n ? result_n : mem_wdata;

    // A committed write to either FSR mirror updates the shadow copy
    fsr_n = fsr;
    if ((state == ST_WB) && (mem_rd_wr == WR) && (ea_q[FADDR_W-1:0] == FSR_ADDR))
      fsr_n = result_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsr        <= '0;
      ea_q       <= '0;
      null_q     <= 1'b0;
      dest_mem_q <= 1'b0;
      result_q   <= '0;
      req_ready  <= 1'b1;
      op_valid   <= 1'b0;
      op_data    <= '0;
      w_we       <= 1'b0;
      w_data     <= '0;
      mem_rd_wr  <= RD;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      fsr        <= fsr_n;
      ea_q       <= ea_n;
      null_q     <= null_n;
      dest_mem_q <= dest_mem_n;
      result_q   <= result_n;
      req_ready  <= req_ready_n;
      op_valid   <= op_valid_n;
      op_data    <= op_data_n;
      w_we       <= w_we_n;
      w_data     <= w_data_n;
      mem_rd_wr  <= mem_rd_wr_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
    end
  end

endmodule

// File: doc/file_reg_access.md
# file_reg_access

Operand-fetch / write-back sequencer placed directly upstream of `Data_Memory` in the PIC_RISC datapath. It takes one file-register operation from the decoder and resolves the effective address, using either direct addressing with the bank bit or indirect addressing through INDF/FSR. It reads the operand from data memory, hands it to the ALU and collects the result. The result is then written back to data memory or to W. The block keeps a shadow copy of FSR by snooping its own writes.

## Interface
- `INDF_ADDR`, 7'h00: f-field value that selects indirect addressing.
- `FSR_ADDR`, 7'h04: low 7 bits of the FSR location, mirrored in both banks (0x04/0x84).
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: decoder presents an operation.
- `req_ready` out 1: high only in IDLE; an operation is accepted on an edge where `req_valid && req_ready`.
- `req_faddr` in 7: the instruction's f field.
- `req_rp` in 1: bank bit (STATUS.RP0).
- `req_rd` in 1: 1 = read-modify-write op; 0 = write-only op (MOVWF/CLRF).
- `req_wb` in 1: destination bit d; 1 = memory, 0 = W. Ignored when `req_rd`=0, because write-only ops always go to memory.
- `req_wdata` in 8: data for write-only ops.
- `op_valid` out 1: `op_data` is valid for the ALU.
- `op_data` out 8: fetched operand.
- `res_valid` in 1: ALU result handshake.
- `res_data` in 8: ALU result.
- `w_we` out 1: one-cycle write strobe to W.
- `w_data` out 8: data for W.
- `mem_rd_wr` out 1: 1 = read, 0 = write. Drives `Data_Memory.rd_wr`.
- `mem_addr` out 8: drives `Data_Memory.address`.
- `mem_wdata` out 8: drives `Data_Memory.data_in`.
- `mem_rdata` in 8: from `Data_Memory.data_bus`.
- `busy` out 1: equals `!req_ready`.

## Operation
- **States:** IDLE, RD, CAP, OP, WB.
- **Address capture at accept:**
  - `ea` = `fsr` if `req_faddr == INDF_ADDR`, otherwise `{req_rp, req_faddr}`.
  - `null` = indirect && `fsr[6:0] == 0`.
  - `ea`, `null`, `req_rd`, `req_wb` and `req_wdata` are all latched at this point.
- **IDLE:**
  - Accept with `req_rd`=1 → RD.
  - Accept with `req_rd`=0 → WB, with the result register loaded from `req_wdata`.
- **RD:** `mem_addr`=`ea`, `mem_rd_wr`=1 → CAP.
- **CAP:** `op_data` ← `null ? 0 : mem_rdata` → OP.
- **OP:**
  - `op_valid`=1, held until `res_valid` is sampled high.
  - On that edge: result register ← `res_data` → WB.
  - If `res_valid` is already high on entry, the result is taken on the first OP edge.
- **WB (exactly one cycle):**
  - Memory destination and `!null`: `mem_rd_wr`=0, `mem_addr`=`ea`, `mem_wdata`=result.
  - W destination: `w_we`=1, `w_data`=result, and `mem_rd_wr` stays 1.
  - `null` with memory destination: write is suppressed and `mem_rd_wr` stays 1.
  - Then → IDLE.
- **FSR snoop:** a committed memory write with `ea[6:0] == FSR_ADDR` loads `fsr` ← result on the same edge. The new value applies to the next accepted request.
- **Ignored inputs:**
  - `res_valid` outside OP is ignored.
  - `req_valid` while busy is ignored; the decoder must hold its request.
- **Idle bus:** outside WB, `mem_rd_wr` is 1. The block never issues a write unless it is in WB.

## Timing
- **Reset values:**
  - State IDLE; `req_ready`=1, `busy`=0.
  - `op_valid`=0, `op_data`=0, `w_we`=0, `w_data`=0.
  - `mem_rd_wr`=1, `mem_addr`=0, `mem_wdata`=0, `fsr`=0.
- **Data memory read timing:** `Data_Memory` samples the address at the edge that ends RD, and `mem_rdata` is valid throughout CAP.
- **Read-modify-write latency:** accept at edge 0; RD cycle 1; CAP cycle 2; `op_valid` in cycle 3; WB in cycle 3+k+1, where k is the number of OP cycles waited; `req_ready` again one cycle later. Minimum turnaround is 5 cycles.
- **Write-only latency:** accept at edge 0; WB cycle 1; IDLE cycle 2.
- **Reset mid-operation:**
  - Next edge: IDLE with all outputs at reset values.
  - Any pending write is dropped and `fsr` is cleared.
  - No partial handshake survives.
- **Address width:** `ea` is 8 bits and never wraps. Indirect addressing uses the full 8-bit `fsr`; the bank bit is ignored.

## Structure
- **Shared `pic_pkg`:** state enum, `INDF_ADDR`, `FSR_ADDR`, and `RD`=1/`WR`=0 constants for `rd_wr`. `Data_Memory` uses the same constants.
- **Sub-module `ea_gen`:** combinational; inputs `req_faddr`, `req_rp`, `fsr`; outputs `ea`, `null`. It is reused later by the bit-op unit.
- The FSM, result register and FSR shadow stay in `file_reg_access`.

## Test plan
- **Direct RMW:** preload mem[0x25]=8'h10. Send `req_faddr`=7'h25, `rp`=0, `rd`=1, `wb`=1; ALU returns `op_data`+1. Expect `op_data`=8'h10 in cycle 3, a write of 8'h11 to 0x25 in cycle 4, and `req_ready` in cycle 5.
- **Bank 1 to W:** preload mem[0xA0]=8'h5A. Send `faddr`=7'h20, `rp`=1, `wb`=0, ALU passes the operand through. Expect `w_we` pulse with `w_data`=8'h5A and no memory write.
- **Indirect:**
  - MOVWF to 0x04 with `req_wdata`=8'h30 loads `fsr` = 8'h30.
  - Then RMW on `faddr`=0 hits address 0x30.
  - Then write-only to FSR mirror 0x84 with 8'h31 updates `fsr` to 8'h31.
- **INDF via INDF:** `fsr`=8'h80, `faddr`=0, `wb`=1. Expect `op_data`=0 and `mem_rd_wr` never 0 during the operation.
- **ALU stall and stray inputs:** `res_valid` held low for 3 cycles. Expect `op_valid` held and `req_ready` low. `req_valid` and `res_valid` pulses in IDLE/RD cause no effect.
- **Reset in OP:** assert `reset` while `op_valid`=1. Next cycle all outputs are at reset values, `mem_rd_wr`=1, and the target memory location is unchanged.
